// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer
//   Shares the single memory port between three requesters: instruction
//   fetch, data load/store and exception vector read. A winner is picked in
//   IDLE with fixed priority exc > data > fetch. The access is held for
//   MEM_LATENCY cycles and finished with a one-cycle ack to the winner.
//   Sits between the main control FSM and the memory/address-mux datapath.
//
// Parameters
//   MEM_LATENCY  cycles address/mem_wr are held stable per access (1..15)
//   CNT_W        latency counter width, 2**CNT_W > MEM_LATENCY
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_fetch  in   fetch request, level, held until ack_fetch
//   req_data   in   data request, level, held until ack_data
//   data_wr    in   1=store, 0=load, sampled when data is granted
//   req_exc    in   exception vector read request, held until ack_exc
//   addr_sel   out  address mux select: 00 PC, 01 ALUOut, 10 exc vector
//   mem_wr     out  memory write enable (ACCESS phase of a store only)
//   grant      out  one-hot owner {exc,data,fetch}, 000 when idle
//   ack_fetch  out  one-cycle completion pulse for fetch
//   ack_data   out  one-cycle completion pulse for data
//   ack_exc    out  one-cycle completion pulse for exception read
//   busy       out  high whenever the sequencer is not idle
module mem_port_sequencer #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_fetch,
    input  logic       req_data,
    input  logic       data_wr,
    input  logic       req_exc,
    output logic [1:0] addr_sel,
    output logic       mem_wr,
    output logic [2:0] grant,
    output logic       ack_fetch,
    output logic       ack_data,
    output logic       ack_exc,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_ACK    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    // Mux legs and one-hot owner codes, bit order {exc,data,fetch}.
    localparam logic [1:0] SEL_PC  = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b01;
    localparam logic [1:0] SEL_EXC = 2'b10;
    localparam logic [2:0] OWN_FETCH = 3'b001;
    localparam logic [2:0] OWN_DATA  = 3'b010;
    localparam logic [2:0] OWN_EXC   = 3'b100;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       grant_reg, grant_next;
    logic [1:0]       addr_sel_reg, addr_sel_next;
    logic             wr_reg, wr_next;
    logic             ack_phase;
    logic [2:0]       ack_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            grant_reg    <= 3'b000;
            addr_sel_reg <= SEL_PC;
            wr_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            grant_reg    <= grant_next;
            addr_sel_reg <= addr_sel_next;
            wr_reg       <= wr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        grant_next    = grant_reg;
        addr_sel_next = addr_sel_reg;
        wr_next       = wr_reg;
        addr_sel      = addr_sel_reg;
        grant         = grant_reg;
        mem_wr        = 1'b0;
        ack_phase     = 1'b0;
        busy          = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                busy  = 1'b0;
                grant = 3'b000;
                // Arbitration only happens here, so a request arriving
                // mid-access simply waits for the next IDLE cycle.
                if (req_exc) begin
                    grant_next    = OWN_EXC;
                    addr_sel_next = SEL_EXC;
                    wr_next       = 1'b0;
                end else if (req_data) begin
                    grant_next    = OWN_DATA;
                    addr_sel_next = SEL_ALU;
                    wr_next       = data_wr;
                end else if (req_fetch) begin
                    grant_next    = OWN_FETCH;
                    addr_sel_next = SEL_PC;
                    wr_next       = 1'b0;
                end
                if (req_exc || req_data || req_fetch) begin
                    cnt_next   = CNT_LOAD;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // The write latch is only ever set for a data store, so
                // fetch and exception reads never write.
                mem_wr = wr_reg;
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_phase  = 1'b1;
                state_next = ST_IDLE;
                grant_next = 3'b000;
                wr_next    = 1'b0;
            end
            default: begin
                // Illegal encoding: present reset-valued outputs and recover.
                addr_sel      = SEL_PC;
                grant         = 3'b000;
                busy          = 1'b0;
                state_next    = ST_IDLE;
                cnt_next      = '0;
                grant_next    = 3'b000;
                addr_sel_next = SEL_PC;
                wr_next       = 1'b0;
            end
        endcase
    end

    // Each ack bit follows the matching grant bit during the ACK phase.
    for (genvar gi = 0; gi < 3; gi++) begin : g_ack
        assign ack_vec[gi] = ack_phase & grant_reg[gi];
    end

    assign ack_fetch = ack_vec[0];
    assign ack_data  = ack_vec[1];
    assign ack_exc   = ack_vec[2];

endmodule

// File: tb/tb_mem_port_sequencer.sv
module tb_mem_port_sequencer;

    logic       clk;
    logic       reset_n;
    logic       req_fetch, req_data, data_wr, req_exc;
    logic [1:0] addr_sel;
    logic       mem_wr, ack_fetch, ack_data, ack_exc, busy;
    logic [2:0] grant;
    logic [9:0] obs;

    // Requesters for the MEM_LATENCY=1 (bit 0) and =5 (bit 1) instances.
    logic [1:0] rq_f, rq_d, rq_w, rq_e;
    logic [1:0] l1_addr_sel, l5_addr_sel;
    logic [2:0] l1_grant, l5_grant;
    logic       l1_mem_wr, l1_ack_fetch, l1_ack_data, l1_ack_exc, l1_busy;
    logic       l5_mem_wr, l5_ack_fetch, l5_ack_data, l5_ack_exc, l5_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_port_sequencer #(.MEM_LATENCY(2), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_fetch(req_fetch), .req_data(req_data), .data_wr(data_wr), .req_exc(req_exc),
        .addr_sel(addr_sel), .mem_wr(mem_wr), .grant(grant),
        .ack_fetch(ack_fetch), .ack_data(ack_data), .ack_exc(ack_exc), .busy(busy)
    );

    mem_port_sequencer #(.MEM_LATENCY(1), .CNT_W(4)) u_l1 (
        .clk(clk), .reset_n(reset_n),
        .req_fetch(rq_f[0]), .req_data(rq_d[0]), .data_wr(rq_w[0]), .req_exc(rq_e[0]),
        .addr_sel(l1_addr_sel), .mem_wr(l1_mem_wr), .grant(l1_grant),
        .ack_fetch(l1_ack_fetch), .ack_data(l1_ack_data), .ack_exc(l1_ack_exc), .busy(l1_busy)
    );

    mem_port_sequencer #(.MEM_LATENCY(5), .CNT_W(4)) u_l5 (
        .clk(clk), .reset_n(reset_n),
        .req_fetch(rq_f[1]), .req_data(rq_d[1]), .data_wr(rq_w[1]), .req_exc(rq_e[1]),
        .addr_sel(l5_addr_sel), .mem_wr(l5_mem_wr), .grant(l5_grant),
        .ack_fetch(l5_ack_fetch), .ack_data(l5_ack_data), .ack_exc(l5_ack_exc), .busy(l5_busy)
    );

    assign obs = {busy, grant, addr_sel, mem_wr, ack_exc, ack_data, ack_fetch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected observation vector for the MEM_LATENCY=2 DUT.
    // ph: 0 idle, 1 access, 2 ack.
    function automatic logic [9:0] mk(input logic [2:0] own, input int ph,
                                      input logic [1:0] a, input logic w);
        logic [2:0] g;
        g = (ph != 0) ? own : 3'b000;
        return {ph != 0, g, a, (ph == 1) && w, (ph == 2) ? own : 3'b000};
    endfunction

    // Phase at cycle c for an access granted starting at cycle s (latency 2).
    function automatic int phase_of(input int c, input int s);
        if (c >= s && c <= s + 1) return 1;
        if (c == s + 2) return 2;
        return 0;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        req_fetch = 0; req_data = 0; data_wr = 0; req_exc = 0;
        rq_f = '0; rq_d = '0; rq_w = '0; rq_e = '0;
        #2;
        tests_run++;
        if (obs !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: got %b expected %b", obs, 10'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (obs !== 10'b0) begin
                tests_failed++;
                $display("FAIL reset_idle: got %b expected %b", obs, 10'b0);
            end
        end
    endtask

    task automatic test_fetch();
        logic [9:0] exp_v;
        @(posedge clk); #1;
        req_fetch = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            exp_v = mk(3'b001, phase_of(c, 1), 2'b00, 1'b0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL fetch cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c == 3) req_fetch = 1'b0;
        end
    endtask

    task automatic test_store();
        logic [9:0] exp_v;
        @(posedge clk); #1;
        req_data = 1'b1; data_wr = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            exp_v = mk(3'b010, phase_of(c, 1), (c == 0) ? 2'b00 : 2'b01, 1'b1);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL store cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c == 3) begin req_data = 1'b0; data_wr = 1'b0; end
        end
    endtask

    task automatic test_priority();
        logic [9:0] exp_v;
        logic [2:0] own;
        logic [1:0] a;
        int ph;
        @(posedge clk); #1;
        req_fetch = 1'b1; req_data = 1'b1; req_exc = 1'b1; data_wr = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            own = 3'b000; ph = 0;
            if (phase_of(c, 1) != 0) begin own = 3'b100; ph = phase_of(c, 1); end
            if (phase_of(c, 5) != 0) begin own = 3'b010; ph = phase_of(c, 5); end
            if (phase_of(c, 9) != 0) begin own = 3'b001; ph = phase_of(c, 9); end
            if (c == 0)      a = 2'b01;
            else if (c <= 4) a = 2'b10;
            else if (c <= 8) a = 2'b01;
            else             a = 2'b00;
            exp_v = mk(own, ph, a, 1'b0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL priority cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c == 3)  req_exc   = 1'b0;
            if (c == 7)  req_data  = 1'b0;
            if (c == 11) req_fetch = 1'b0;
        end
    endtask

    task automatic test_no_preempt();
        logic [9:0] exp_v;
        logic [2:0] own;
        int ph;
        int n_ack_f, n_ack_e;
        n_ack_f = 0; n_ack_e = 0;
        @(posedge clk); #1;
        req_fetch = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            own = 3'b000; ph = 0;
            if (phase_of(c, 1) != 0) begin own = 3'b001; ph = phase_of(c, 1); end
            if (phase_of(c, 5) != 0) begin own = 3'b100; ph = phase_of(c, 5); end
            exp_v = mk(own, ph, (c <= 4) ? 2'b00 : 2'b10, 1'b0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL no_preempt cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (ack_fetch === 1'b1) n_ack_f++;
            if (ack_exc === 1'b1) n_ack_e++;
            if (c == 1) req_exc   = 1'b1;
            if (c == 3) req_fetch = 1'b0;
            if (c == 7) req_exc   = 1'b0;
        end
        tests_run++;
        if (n_ack_f != 1 || n_ack_e != 1) begin
            tests_failed++;
            $display("FAIL no_preempt_ack_count: got fetch=%0d exc=%0d expected 1 and 1", n_ack_f, n_ack_e);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_v;
        int ph;
        @(posedge clk); #1;
        req_fetch = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            ph = phase_of(c, 1) + phase_of(c, 5);
            exp_v = mk(3'b001, ph, (c == 0) ? 2'b10 : 2'b00, 1'b0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c == 5) req_fetch = 1'b0;
        end
    endtask

    task automatic test_req_drop();
        logic [9:0] exp_v;
        @(posedge clk); #1;
        req_data = 1'b1; data_wr = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            exp_v = mk(3'b010, phase_of(c, 1), (c == 0) ? 2'b00 : 2'b01, 1'b0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL req_drop cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c == 1) req_data = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access();
        logic [9:0] exp_v;
        @(posedge clk); #1;
        req_data = 1'b1; data_wr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_v = mk(3'b010, 1, 2'b01, 1'b1);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: got %b expected %b", obs, exp_v);
        end
        #2;
        reset_n = 1'b0;
        req_data = 1'b0; data_wr = 1'b0;
        #1;
        tests_run++;
        if (obs !== 10'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got %b expected %b", obs, 10'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (obs !== 10'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_after cycle %0d: got %b expected %b", c, obs, 10'b0);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] req_now [2];
        logic [2:0] req_prev[2];
        logic [2:0] g_prev  [2];
        int         gstart  [2];
        int         lat     [2];
        logic [2:0] g, ak, win;
        logic [1:0] a;
        logic       mw, bz, w, exp_mw;
        lat[0] = 1; lat[1] = 5;
        for (int i = 0; i < 2; i++) begin
            req_now[i] = 3'b000; req_prev[i] = 3'b000; g_prev[i] = 3'b000; gstart[i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    g = l1_grant; ak = {l1_ack_exc, l1_ack_data, l1_ack_fetch};
                    a = l1_addr_sel; mw = l1_mem_wr; bz = l1_busy;
                end else begin
                    g = l5_grant; ak = {l5_ack_exc, l5_ack_data, l5_ack_fetch};
                    a = l5_addr_sel; mw = l5_mem_wr; bz = l5_busy;
                end
                w = rq_w[i];
                tests_run++;
                if (!$onehot0(g) || $isunknown(g)) begin
                    tests_failed++;
                    $display("FAIL rnd_onehot L=%0d cyc %0d: got %b expected one-hot or 000", lat[i], cyc, g);
                end
                tests_run++;
                if (a === 2'b11 || $isunknown(a)) begin
                    tests_failed++;
                    $display("FAIL rnd_addr_sel L=%0d cyc %0d: got %b expected not 11", lat[i], cyc, a);
                end
                tests_run++;
                if (bz !== (g != 3'b000)) begin
                    tests_failed++;
                    $display("FAIL rnd_busy L=%0d cyc %0d: got %b expected %b", lat[i], cyc, bz, g != 3'b000);
                end
                if (g_prev[i] == 3'b000 && g != 3'b000) begin
                    gstart[i] = cyc;
                    if (req_prev[i][2])      win = 3'b100;
                    else if (req_prev[i][1]) win = 3'b010;
                    else if (req_prev[i][0]) win = 3'b001;
                    else                     win = 3'b000;
                    tests_run++;
                    if (g !== win) begin
                        tests_failed++;
                        $display("FAIL rnd_winner L=%0d cyc %0d: got %b expected %b", lat[i], cyc, g, win);
                    end
                end
                exp_mw = (g == 3'b010 && ak == 3'b000) ? w : 1'b0;
                tests_run++;
                if (mw !== exp_mw) begin
                    tests_failed++;
                    $display("FAIL rnd_mem_wr L=%0d cyc %0d: got %b expected %b", lat[i], cyc, mw, exp_mw);
                end
                if (ak != 3'b000) begin
                    tests_run++;
                    if (ak !== g || (ak & req_now[i]) !== ak || cyc - gstart[i] != lat[i]) begin
                        tests_failed++;
                        $display("FAIL rnd_ack L=%0d cyc %0d: got ack %b grant %b req %b delay %0d expected ack=grant, outstanding, delay %0d",
                                 lat[i], cyc, ak, g, req_now[i], cyc - gstart[i], lat[i]);
                    end
                    req_now[i] = req_now[i] & ~ak;
                end
                g_prev[i] = g;
                for (int b = 0; b < 3; b++) begin
                    if (!req_now[i][b] && $urandom_range(0, 3) == 0) begin
                        req_now[i][b] = 1'b1;
                        if (b == 1) rq_w[i] = 1'($urandom_range(0, 1));
                    end
                end
                req_prev[i] = req_now[i];
                rq_f[i] = req_now[i][0];
                rq_d[i] = req_now[i][1];
                rq_e[i] = req_now[i][2];
            end
        end
        rq_f = '0; rq_d = '0; rq_e = '0; rq_w = '0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_no_preempt();
        test_back_to_back();
        test_req_drop();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
